// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack memory
// handshakes, a shared request timeout, and sticky illegal/bus-error flags.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       ir_write,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] ALUOp,
    output logic [1:0] wb_sel,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       instr_retired,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_JALR  = 7'd103;
    localparam logic [6:0] OP_BR    = 7'd99;
    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_AUIPC = 7'd23;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic       legal_op;
    logic       timeout;
    logic [1:0] alu_op_c;
    logic       src_a_c;
    logic       src_b_c;

    always_comb begin
        legal_op = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL,
                                  OP_JALR, OP_BR, OP_LUI, OP_AUIPC};
        src_a_c  = (opcode == OP_AUIPC);
        src_b_c  = opcode inside {OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC};
        case (opcode)
            OP_R:          alu_op_c = 2'b10;
            OP_I, OP_JALR: alu_op_c = 2'b11;
            OP_BR:         alu_op_c = 2'b01;
            default:       alu_op_c = 2'b00;
        endcase
        timeout = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 1'b0;
        ALUOp         = 2'b00;
        wb_sel        = 2'b00;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        instr_retired = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (legal_op) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                ALUOp     = alu_op_c;
                alu_src_a = src_a_c;
                alu_src_b = src_b_c;
                case (opcode)
                    OP_BR: begin
                        pc_write      = 1'b1;
                        pc_src        = branch_taken ? 2'b01 : 2'b00;
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        reg_write     = 1'b1;
                        wb_sel        = 2'b10;
                        pc_write      = 1'b1;
                        pc_src        = (opcode == OP_JAL) ? 2'b01 : 2'b10;
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                ALUOp     = alu_op_c;
                alu_src_a = src_a_c;
                alu_src_b = src_b_c;
                dmem_req  = 1'b1;
                dmem_we   = (opcode == OP_STORE);
                if (dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write     = 1'b1;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
                if (opcode == OP_LOAD)     wb_sel = 2'b01;
                else if (opcode == OP_LUI) wb_sel = 2'b11;
            end
            S_HALT:  ;
            default: state_d = S_HALT;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Strobes are forced low while reset is asserted so no request leaks out.
        if (!rst_n) begin
            imem_req      = 1'b0;
            ir_write      = 1'b0;
            dmem_req      = 1'b0;
            dmem_we       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 1'b0;
            ALUOp         = 2'b00;
            wb_sel        = 2'b00;
            pc_write      = 1'b0;
            pc_src        = 2'b00;
            instr_retired = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction cycle schedule is
// derived from opcode class and memory wait counts, then compared every cycle.
module tb_multicycle_control;

    localparam int unsigned TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       imem_ack, dmem_ack, branch_taken;
    logic       imem_req, ir_write, dmem_req, dmem_we, reg_write;
    logic       alu_src_a, alu_src_b, pc_write, instr_retired, illegal, bus_err;
    logic [1:0] ALUOp, wb_sel, pc_src;
    logic [2:0] state_o;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;
    logic ill_m = 1'b0;
    logic berr_m = 1'b0;
    logic [6:0] legal_ops [9] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd111, 7'd103, 7'd99, 7'd55, 7'd23};

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req),
        .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ALUOp(ALUOp), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
        .instr_retired(instr_retired), .illegal(illegal), .bus_err(bus_err),
        .state_o(state_o)
    );

    assign obs = {state_o, imem_req, ir_write, dmem_req, dmem_we, reg_write,
                  alu_src_a, alu_src_b, ALUOp, wb_sel, pc_write, pc_src,
                  instr_retired, illegal, bus_err};

    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Field order: state, imem_req, ir_write, dmem_req, dmem_we, reg_write,
    // alu_src_a, alu_src_b, ALUOp, wb_sel, pc_write, pc_src, instr_retired.
    function automatic logic [19:0] pk(input logic [2:0] st, input logic imr, input logic irw,
                                       input logic dr, input logic dw, input logic rw,
                                       input logic sa, input logic sb, input logic [1:0] aop,
                                       input logic [1:0] wbs, input logic pcw,
                                       input logic [1:0] pcs, input logic ret);
        return {st, imr, irw, dr, dw, rw, sa, sb, aop, wbs, pcw, pcs, ret, ill_m, berr_m};
    endfunction

    task automatic cyc(input string tag, input logic ia, input logic da, input logic bt,
                       input logic [6:0] op, input logic [19:0] exp, input logic rn);
        @(negedge clk);
        imem_ack = ia; dmem_ack = da; branch_taken = bt; opcode = op; rst_n = rn;
        #1;
        check_eq(tag, obs, exp);
    endtask

    task automatic reset_cycle(input logic [2:0] cur);
        cyc("reset", rb(), rb(), rb(), rop(), pk(cur, 0,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,0), 1'b0);
        ill_m = 1'b0;
        berr_m = 1'b0;
    endtask

    task automatic halt_and_reset();
        int unsigned k = $urandom_range(1, 3);
        for (int unsigned i = 0; i < k; i++)
            cyc("halt", rb(), rb(), rb(), rop(), pk(3'd7, 0,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,0), 1'b1);
        reset_cycle(3'd7);
    endtask

    task automatic run_instr(input logic [6:0] op, input int unsigned wi, input int unsigned wd,
                             input logic bt, input logic abort);
        logic ld, st, sa, sb;
        logic [1:0] aop, wbs;
        ld  = (op == 7'd3);
        st  = (op == 7'd35);
        sa  = (op == 7'd23);
        sb  = (op == 7'd19) || ld || st || (op == 7'd103) || (op == 7'd23);
        aop = (op == 7'd51) ? 2'b10 : (op == 7'd19 || op == 7'd103) ? 2'b11 :
              (op == 7'd99) ? 2'b01 : 2'b00;

        for (int unsigned n = 0; n < wi && n < TO; n++)
            cyc("fetch_wait", 1'b0, rb(), rb(), rop(), pk(3'd0, 1,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,0), 1'b1);
        if (wi >= TO) begin
            berr_m = 1'b1;
            halt_and_reset();
            return;
        end
        cyc("fetch_ack", 1'b1, rb(), rb(), rop(), pk(3'd0, 1,1,0,0,0,0,0,2'd0,2'd0,0,2'd0,0), 1'b1);
        cyc("decode", rb(), rb(), rb(), op, pk(3'd1, 0,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,0), 1'b1);
        if (!is_legal(op)) begin
            ill_m = 1'b1;
            halt_and_reset();
            return;
        end

        case (op)
            7'd99: begin
                cyc("exec_branch", rb(), rb(), bt, op,
                    pk(3'd2, 0,0,0,0,0,sa,sb,aop,2'd0,1,bt ? 2'd1 : 2'd0,1), 1'b1);
                return;
            end
            7'd111: begin
                cyc("exec_jal", rb(), rb(), rb(), op, pk(3'd2, 0,0,0,0,1,sa,sb,aop,2'd2,1,2'd1,1), 1'b1);
                return;
            end
            7'd103: begin
                cyc("exec_jalr", rb(), rb(), rb(), op, pk(3'd2, 0,0,0,0,1,sa,sb,aop,2'd2,1,2'd2,1), 1'b1);
                return;
            end
            default:
                cyc("exec", rb(), rb(), rb(), op, pk(3'd2, 0,0,0,0,0,sa,sb,aop,2'd0,0,2'd0,0), 1'b1);
        endcase

        if (ld || st) begin
            for (int unsigned n = 0; n < wd && n < TO; n++) begin
                if (abort && n == 1) begin
                    reset_cycle(3'd3);
                    return;
                end
                cyc("mem_wait", rb(), 1'b0, rb(), op, pk(3'd3, 0,0,1,st,0,sa,sb,aop,2'd0,0,2'd0,0), 1'b1);
            end
            if (wd >= TO) begin
                berr_m = 1'b1;
                halt_and_reset();
                return;
            end
            if (st) begin
                cyc("mem_store_ack", rb(), 1'b1, rb(), op, pk(3'd3, 0,0,1,1,0,sa,sb,aop,2'd0,1,2'd0,1), 1'b1);
                return;
            end
            cyc("mem_load_ack", rb(), 1'b1, rb(), op, pk(3'd3, 0,0,1,0,0,sa,sb,aop,2'd0,0,2'd0,0), 1'b1);
        end

        wbs = ld ? 2'd1 : (op == 7'd55) ? 2'd3 : 2'd0;
        cyc("wb", rb(), rb(), rb(), op, pk(3'd4, 0,0,0,0,1,0,0,2'd0,wbs,1,2'd0,1), 1'b1);
    endtask

    function automatic int unsigned rwait();
        if ($urandom_range(0, 9) == 0) return TO - 1 + $urandom_range(0, 2);
        return $urandom_range(0, 3);
    endfunction

    initial begin
        logic [6:0] op;
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; opcode = '0;
        cyc("reset_state", rb(), rb(), rb(), rop(), pk(3'd0, 0,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,0), 1'b0);

        run_instr(7'd51, 0, 0, 1'b0, 1'b0);
        run_instr(7'd3, 0, 3, 1'b0, 1'b0);
        run_instr(7'd99, 0, 0, 1'b1, 1'b0);
        run_instr(7'd99, 0, 0, 1'b0, 1'b0);
        run_instr(7'd103, 0, 0, 1'b0, 1'b0);
        run_instr(7'd51, TO, 0, 1'b0, 1'b0);
        run_instr(7'd55, TO - 1, 0, 1'b0, 1'b0);
        run_instr(7'h7F, 0, 0, 1'b0, 1'b0);
        run_instr(7'd35, 0, TO, 1'b0, 1'b0);
        run_instr(7'd3, 0, TO - 1, 1'b0, 1'b0);
        run_instr(7'd3, 0, 4, 1'b0, 1'b1);

        for (int unsigned i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = rop(); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            run_instr(op, rwait(), rwait(), rb(), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
